ascii_hex_accum: RTL and testbench
==================================

Name: ascii_hex_accum

Overview:
- Sequential successor of the single-character ASCII-to-hex decoder.
- Takes the received-byte stream from the UART RX path, one byte per valid strobe, and shifts hex digits into a DIGITS-wide accumulator.
- Emits a registered word when the word is full or a terminator arrives. Flags invalid characters and inter-character timeouts.
- Sits between the UART receiver and the command/register logic.

Parameters:
- DIGITS, 4, hex digits per word; WIDTH = 4*DIGITS (localparam); legal range 1..8.
- LOWER_EN, 1, 1 = accept 'a'-'f' (0x61-0x66) as 10-15; 0 = lowercase is an invalid char.
- TERM_CHAR, 8'h0D, terminator byte (CR); flushes a partial word.
- TIMEOUT_CYC, 0, idle cycles allowed between digits inside a word; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  one-cycle strobe: in_data holds a received byte
- in_data  in  8  received ASCII byte
- word_valid  out  1  one-cycle pulse: word_data/word_len valid
- word_data  out  WIDTH  assembled value, right-aligned, zero-extended
- word_len  out  $clog2(DIGITS+1)  number of digits in the emitted word (1..DIGITS)
- err  out  1  one-cycle pulse on error
- err_code  out  2  01 = invalid char, 10 = timeout; held until the next err pulse
- busy  out  1  high while a partial word is held (cnt != 0)

Behaviour:
- Reset: acc=0, cnt=0, tmo=0, state IDLE. word_valid=0, word_data=0, word_len=0, err=0, err_code=00, busy=0.
- Byte classes: hex digit ('0'-'9', 'A'-'F', plus 'a'-'f' if LOWER_EN), TERM_CHAR, other. TERM_CHAR takes precedence if it collides with a digit code.
- States:
  - IDLE: cnt==0.
  - ACCUM: 0 < cnt < DIGITS.
  - No separate output state; emission is a registered pulse.
- Hex digit:
  - acc <= {acc[WIDTH-5:0], nibble} (for DIGITS==1, acc <= nibble); cnt++; tmo cleared.
  - If cnt reaches DIGITS, emit on the next cycle: word_valid=1, word_data=new acc, word_len=DIGITS. Then acc=0, cnt=0, state IDLE.
- TERM_CHAR:
  - In ACCUM: emit acc with word_len=cnt, then clear to IDLE.
  - In IDLE: ignored, no pulse.
- Other byte:
  - err=1, err_code=01 next cycle. acc/cnt cleared and state IDLE; any partial word is discarded.
  - Applies in IDLE as well.
- Timeout (TIMEOUT_CYC>0):
  - In ACCUM, tmo counts cycles without in_valid.
  - When tmo==TIMEOUT_CYC-1 and in_valid=0: err=1, err_code=10 next cycle; partial word discarded; IDLE.
  - An in_valid in that same cycle wins: the byte is processed and no timeout fires.
  - tmo is held at 0 in IDLE.
- Latency: exactly 1 clk from the completing in_valid to word_valid or err. At most one of word_valid/err per cycle.
- Back-to-back: in_valid may be high every cycle. A byte arriving in the same cycle as word_valid starts the next word with no loss.
- word_data/word_len hold their last values between pulses. word_data is meaningful only while word_valid is high.
- in_valid while rst is high: ignored. Reset mid-word discards the partial word and no pulse follows.
- Width rule: nibble is 4 bits. The shift drops the MSB nibble only on the full-word path, after emission, so no truncation of accepted data.

Decomposition:
- Package ascii_hex_pkg:
  - Char constants: CHR_0=8'h30, CHR_9=8'h39, CHR_UA=8'h41, CHR_UF=8'h46, CHR_LA=8'h61, CHR_LF=8'h66, CHR_CR=8'h0D.
  - ERR_NONE=2'b00, ERR_BADCHR=2'b01, ERR_TMO=2'b10.
- Sub-module ascii_hex_nibble (combinational):
  - Inputs: in_data, LOWER_EN.
  - Outputs: is_hex, nibble[3:0].
  - Range compares instead of a 16-entry case.

Test Plan:
- DIGITS=4: bytes "1","A","f","3" on consecutive cycles -> word_valid one cycle after the "3" strobe, word_data=16'h1AF3, word_len=3'd4, busy back to 0.
- DIGITS=4: "7","C",0x0D -> word_data=16'h007C, word_len=2; a further 0x0D alone -> no pulse.
- LOWER_EN=0: "2","g" -> err=1, err_code=01 one cycle after "g", no word_valid; then "1","2","3","4" -> 16'h1234.
- TIMEOUT_CYC=10: "5", then 10 idle cycles -> err, err_code=10, busy=0; repeat with "5" at idle cycle 9 followed by "6","7","8" -> word 16'h5678, no err.
- Continuous in_valid every cycle, "12345678" with DIGITS=4 -> two pulses 4 cycles apart: 16'h1234 then 16'h5678.
- rst asserted asynchronously after "9","9" -> all outputs 0 immediately; after release, 0x0D gives no pulse and "ABCD" gives 16'hABCD.

Source files
------------

// File: rtl/ascii_hex_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ascii_hex_pkg
// Purpose  : Shared character codes, error codes and state type for the
//            ASCII hex word accumulator.
// Revision : 1.0 - initial release
// ============================================================================
package ascii_hex_pkg;

  localparam logic [7:0] CHR_0  = 8'h30;
  localparam logic [7:0] CHR_9  = 8'h39;
  localparam logic [7:0] CHR_UA = 8'h41;
  localparam logic [7:0] CHR_UF = 8'h46;
  localparam logic [7:0] CHR_LA = 8'h61;
  localparam logic [7:0] CHR_LF = 8'h66;
  localparam logic [7:0] CHR_CR = 8'h0D;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_BADCHR = 2'b01;
  localparam logic [1:0] ERR_TMO    = 2'b10;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ascii_hex_nibble.sv
`default_nettype none
// ============================================================================
// Module   : ascii_hex_nibble
// Purpose  : Combinational classifier turning one ASCII byte into a hex nibble.
// Revision : 1.0 - initial release
// ============================================================================
module ascii_hex_nibble
  import ascii_hex_pkg::*;
#(
  parameter bit LOWER_EN = 1'b1
) (
  input  logic [7:0] in_data,
  output logic       is_hex,
  output logic [3:0] nibble
);

  logic w_dec;
  logic w_upper;
  logic w_lower;

  assign w_dec   = (in_data >= CHR_0)  && (in_data <= CHR_9);
  assign w_upper = (in_data >= CHR_UA) && (in_data <= CHR_UF);
  assign w_lower = LOWER_EN && (in_data >= CHR_LA) && (in_data <= CHR_LF);

  assign is_hex = w_dec | w_upper | w_lower;
  // Both letter ranges start at low nibble 1, so +9 maps them onto 10..15.
  assign nibble = w_dec ? in_data[3:0] : (in_data[3:0] + 4'd9);

endmodule
`default_nettype wire

// File: rtl/ascii_hex_accum.sv
`default_nettype none
// ============================================================================
// Module   : ascii_hex_accum
// Purpose  : Shifts received ASCII hex digits into a word and emits it when
//            full or on a terminator; flags bad characters and timeouts.
// Revision : 1.0 - initial release
// ============================================================================
module ascii_hex_accum
  import ascii_hex_pkg::*;
#(
  parameter int         DIGITS      = 4,
  parameter bit         LOWER_EN    = 1'b1,
  parameter logic [7:0] TERM_CHAR   = CHR_CR,
  parameter int         TIMEOUT_CYC = 0,
  localparam int        WIDTH       = 4 * DIGITS,
  localparam int        LW          = $clog2(DIGITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             word_valid,
  output logic [WIDTH-1:0] word_data,
  output logic [LW-1:0]    word_len,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             busy
);

  localparam int            TW          = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [LW-1:0] c_cnt_last  = LW'(DIGITS - 1);
  localparam logic [LW-1:0] c_full_len  = LW'(DIGITS);
  localparam logic [TW-1:0] c_tmo_last  = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_acc, w_acc_nxt;
  logic [LW-1:0]    r_cnt, w_cnt_nxt;
  logic [TW-1:0]    r_tmo, w_tmo_nxt;
  logic             w_wv_nxt;
  logic [WIDTH-1:0] w_wd_nxt;
  logic [LW-1:0]    w_wl_nxt;
  logic             w_err_nxt;
  logic [1:0]       w_ec_nxt;

  logic             w_is_hex;
  logic [3:0]       w_nib;
  logic [WIDTH-1:0] w_shifted;

  ascii_hex_nibble #(
    .LOWER_EN (LOWER_EN)
  ) u_nibble (
    .in_data (in_data),
    .is_hex  (w_is_hex),
    .nibble  (w_nib)
  );

  if (DIGITS == 1) begin : g_shift_one
    assign w_shifted = w_nib;
  end else begin : g_shift_multi
    assign w_shifted = {r_acc[WIDTH-5:0], w_nib};
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_tmo_nxt   = r_tmo;
    w_wv_nxt    = 1'b0;
    w_wd_nxt    = word_data;
    w_wl_nxt    = word_len;
    w_err_nxt   = 1'b0;
    w_ec_nxt    = err_code;

    if (in_valid) begin
      w_tmo_nxt = '0;
      // Terminator is tested first so it wins over a colliding digit code.
      if (in_data == TERM_CHAR) begin
        if (r_state == ST_ACCUM) begin
          w_wv_nxt    = 1'b1;
          w_wd_nxt    = r_acc;
          w_wl_nxt    = r_cnt;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      end else if (w_is_hex) begin
        if (r_cnt == c_cnt_last) begin
          w_wv_nxt    = 1'b1;
          w_wd_nxt    = w_shifted;
          w_wl_nxt    = c_full_len;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_acc_nxt   = w_shifted;
          w_cnt_nxt   = r_cnt + LW'(1);
          w_state_nxt = ST_ACCUM;
        end
      end else begin
        w_err_nxt   = 1'b1;
        w_ec_nxt    = ERR_BADCHR;
        w_acc_nxt   = '0;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    end else if ((TIMEOUT_CYC > 0) && (r_state == ST_ACCUM)) begin
      if (r_tmo == c_tmo_last) begin
        w_err_nxt   = 1'b1;
        w_ec_nxt    = ERR_TMO;
        w_acc_nxt   = '0;
        w_cnt_nxt   = '0;
        w_tmo_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end else begin
        w_tmo_nxt = r_tmo + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_tmo      <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
      word_len   <= '0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      r_state    <= w_state_nxt;
      r_acc      <= w_acc_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tmo      <= w_tmo_nxt;
      word_valid <= w_wv_nxt;
      word_data  <= w_wd_nxt;
      word_len   <= w_wl_nxt;
      err        <= w_err_nxt;
      err_code   <= w_ec_nxt;
    end
  end

  assign busy = (r_state == ST_ACCUM);

endmodule
`default_nettype wire

// File: tb/tb_ascii_hex_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_ascii_hex_accum
// Purpose  : Directed table, corner sequences and random traffic against two
//            accumulator configurations and a digit-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ascii_hex_accum;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic        a_wv, a_er, a_bz, b_wv, b_er, b_bz;
  logic [15:0] a_wd, b_wd;
  logic [2:0]  a_wl, b_wl;
  logic [1:0]  a_ec, b_ec;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // u_a: lowercase accepted, 10-cycle timeout.  u_b: lowercase rejected, no timeout.
  ascii_hex_accum #(.DIGITS(4), .LOWER_EN(1'b1), .TERM_CHAR(8'h0D), .TIMEOUT_CYC(10)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .word_valid(a_wv), .word_data(a_wd), .word_len(a_wl),
    .err(a_er), .err_code(a_ec), .busy(a_bz)
  );

  ascii_hex_accum #(.DIGITS(4), .LOWER_EN(1'b0), .TERM_CHAR(8'h0D), .TIMEOUT_CYC(0)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .word_valid(b_wv), .word_data(b_wd), .word_len(b_wl),
    .err(b_er), .err_code(b_ec), .busy(b_bz)
  );

  typedef struct {
    int          ndig;
    int          val;
    int          idle;
    logic        wv;
    logic [15:0] wd;
    int          wl;
    logic        er;
    logic [1:0]  ec;
  } mstate_t;

  mstate_t ma, mb;

  function automatic int hexval(logic [7:0] d, bit lower);
    if (d >= 8'h30 && d <= 8'h39) return int'(d) - 48;
    if (d >= 8'h41 && d <= 8'h46) return int'(d) - 55;
    if (lower && d >= 8'h61 && d <= 8'h66) return int'(d) - 87;
    return -1;
  endfunction

  function automatic mstate_t mstep(mstate_t m, bit lower, int tmo, logic v, logic [7:0] d);
    int h;
    m.wv = 1'b0;
    m.er = 1'b0;
    if (v) begin
      m.idle = 0;
      h = hexval(d, lower);
      if (d == 8'h0D) begin
        if (m.ndig > 0) begin
          m.wv = 1'b1; m.wd = 16'(m.val); m.wl = m.ndig;
          m.ndig = 0; m.val = 0;
        end
      end else if (h >= 0) begin
        m.val  = m.val * 16 + h;
        m.ndig = m.ndig + 1;
        if (m.ndig == 4) begin
          m.wv = 1'b1; m.wd = 16'(m.val); m.wl = 4;
          m.ndig = 0; m.val = 0;
        end
      end else begin
        m.er = 1'b1; m.ec = 2'b01;
        m.ndig = 0; m.val = 0;
      end
    end else if (m.ndig > 0 && tmo > 0) begin
      m.idle = m.idle + 1;
      if (m.idle == tmo) begin
        m.er = 1'b1; m.ec = 2'b10;
        m.ndig = 0; m.val = 0; m.idle = 0;
      end
    end
    return m;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic cmp_dut(string tag, mstate_t m, logic wv, logic [15:0] wd, logic [2:0] wl,
                         logic er, logic [1:0] ec, logic bz);
    chk({tag, ".word_valid"}, 32'(wv), 32'(m.wv));
    chk({tag, ".word_data"},  32'(wd), 32'(m.wd));
    chk({tag, ".word_len"},   32'(wl), 32'(m.wl));
    chk({tag, ".err"},        32'(er), 32'(m.er));
    chk({tag, ".err_code"},   32'(ec), 32'(m.ec));
    chk({tag, ".busy"},       32'(bz), 32'(m.ndig > 0));
  endtask

  task automatic cmp_models(string tag);
    cmp_dut({tag, ":a"}, ma, a_wv, a_wd, a_wl, a_er, a_ec, a_bz);
    cmp_dut({tag, ":b"}, mb, b_wv, b_wd, b_wl, b_er, b_ec, b_bz);
  endtask

  // Apply one byte/idle cycle, advance both models, compare one step after the edge.
  task automatic step(input logic v, input logic [7:0] d, input string tag);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    ma = mstep(ma, 1'b1, 10, v, d);
    mb = mstep(mb, 1'b0, 0, v, d);
    #1;
    cmp_models(tag);
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        wv;
    logic [15:0] wd;
    logic [2:0]  wl;
    logic        er;
    logic [1:0]  ec;
    logic        bz;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string pool;
    ma = '{default: 0};
    mb = '{default: 0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    cmp_models("reset");
    rst = 1'b0;

    // Expected values for u_a (lowercase on, timeout 10) straight from the word rules.
    tbl.push_back('{1'b1, "1",   1'b0, 16'h0000, 3'd0, 1'b0, 2'b00, 1'b1});
    tbl.push_back('{1'b1, "A",   1'b0, 16'h0000, 3'd0, 1'b0, 2'b00, 1'b1});
    tbl.push_back('{1'b1, "f",   1'b0, 16'h0000, 3'd0, 1'b0, 2'b00, 1'b1});
    tbl.push_back('{1'b1, "3",   1'b1, 16'h1AF3, 3'd4, 1'b0, 2'b00, 1'b0});
    tbl.push_back('{1'b1, "7",   1'b0, 16'h0000, 3'd0, 1'b0, 2'b00, 1'b1});
    tbl.push_back('{1'b1, "C",   1'b0, 16'h0000, 3'd0, 1'b0, 2'b00, 1'b1});
    tbl.push_back('{1'b1, 8'h0D, 1'b1, 16'h007C, 3'd2, 1'b0, 2'b00, 1'b0});
    tbl.push_back('{1'b1, 8'h0D, 1'b0, 16'h0000, 3'd0, 1'b0, 2'b00, 1'b0});
    tbl.push_back('{1'b1, "g",   1'b0, 16'h0000, 3'd0, 1'b1, 2'b01, 1'b0});
    tbl.push_back('{1'b1, "1",   1'b0, 16'h0000, 3'd0, 1'b0, 2'b00, 1'b1});
    tbl.push_back('{1'b1, "2",   1'b0, 16'h0000, 3'd0, 1'b0, 2'b00, 1'b1});
    tbl.push_back('{1'b1, "3",   1'b0, 16'h0000, 3'd0, 1'b0, 2'b00, 1'b1});
    tbl.push_back('{1'b1, "4",   1'b1, 16'h1234, 3'd4, 1'b0, 2'b00, 1'b0});
    tbl.push_back('{1'b1, "5",   1'b0, 16'h0000, 3'd0, 1'b0, 2'b00, 1'b1});
    tbl.push_back('{1'b1, "6",   1'b0, 16'h0000, 3'd0, 1'b0, 2'b00, 1'b1});
    tbl.push_back('{1'b1, "7",   1'b0, 16'h0000, 3'd0, 1'b0, 2'b00, 1'b1});
    tbl.push_back('{1'b1, "8",   1'b1, 16'h5678, 3'd4, 1'b0, 2'b00, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 16'h0000, 3'd0, 1'b0, 2'b00, 1'b0});

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.wv", i), 32'(a_wv), 32'(tbl[i].wv));
      chk($sformatf("tbl%0d.err", i), 32'(a_er), 32'(tbl[i].er));
      chk($sformatf("tbl%0d.busy", i), 32'(a_bz), 32'(tbl[i].bz));
      if (tbl[i].wv) begin
        chk($sformatf("tbl%0d.wd", i), 32'(a_wd), 32'(tbl[i].wd));
        chk($sformatf("tbl%0d.wl", i), 32'(a_wl), 32'(tbl[i].wl));
      end
      if (tbl[i].er) chk($sformatf("tbl%0d.ec", i), 32'(a_ec), 32'(tbl[i].ec));
    end

    // Lowercase rejected only on u_b
    step(1'b1, "2", "lc0");
    step(1'b1, "g", "lc1");
    chk("lc.b_err", 32'(b_er), 32'd1);
    chk("lc.b_ec", 32'(b_ec), 32'd1);
    chk("lc.b_wv", 32'(b_wv), 32'd0);
    step(1'b1, "a", "lc2");
    chk("lc.b_err_a", 32'(b_er), 32'd1);
    chk("lc.a_busy_a", 32'(a_bz), 32'd1);
    step(1'b1, 8'h0D, "lc3");
    chk("lc.a_flush", 32'(a_wd), 32'h000A);
    chk("lc.a_flush_len", 32'(a_wl), 32'd1);
    step(1'b1, "1", "lc4");
    step(1'b1, "2", "lc5");
    step(1'b1, "3", "lc6");
    step(1'b1, "4", "lc7");
    chk("lc.b_word", 32'(b_wd), 32'h1234);
    chk("lc.b_wv2", 32'(b_wv), 32'd1);

    // Timeout fires on the 10th idle cycle
    step(1'b1, "5", "to0");
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 8'h00, $sformatf("to_idle%0d", i));
      chk($sformatf("to.err_idle%0d", i), 32'(a_er), (i == 10) ? 32'd1 : 32'd0);
    end
    chk("to.ec", 32'(a_ec), 32'd2);
    chk("to.a_busy", 32'(a_bz), 32'd0);
    chk("to.b_busy", 32'(b_bz), 32'd1);
    step(1'b1, 8'h0D, "to_flush_b");
    chk("to.b_flush", 32'(b_wd), 32'h0005);

    // A byte on the last allowed idle cycle beats the timeout
    step(1'b1, "5", "tw0");
    for (int i = 1; i <= 9; i++) step(1'b0, 8'h00, $sformatf("tw_idle%0d", i));
    step(1'b1, "6", "tw1");
    chk("tw.no_err", 32'(a_er), 32'd0);
    step(1'b1, "7", "tw2");
    step(1'b1, "8", "tw3");
    chk("tw.wv", 32'(a_wv), 32'd1);
    chk("tw.word", 32'(a_wd), 32'h5678);

    // Asynchronous reset mid-word
    step(1'b1, "9", "rs0");
    step(1'b1, "9", "rs1");
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    ma = '{default: 0};
    mb = '{default: 0};
    chk("rs.busy_async", 32'(a_bz), 32'd0);
    chk("rs.wd_async", 32'(a_wd), 32'd0);
    cmp_models("rs_async");
    in_valid = 1'b1;
    in_data  = "1";
    @(posedge clk);
    #1;
    cmp_models("rs_held");
    rst = 1'b0;
    step(1'b1, 8'h0D, "rs2");
    chk("rs.no_pulse", 32'(a_wv), 32'd0);
    step(1'b1, "A", "rs3");
    step(1'b1, "B", "rs4");
    step(1'b1, "C", "rs5");
    step(1'b1, "D", "rs6");
    chk("rs.word", 32'(a_wd), 32'hABCD);

    // Random traffic with occasional long idle gaps
    pool = "0123456789ABCDEFabcdef";
    for (int n = 0; n < 400; n++) begin
      int          r;
      logic [7:0]  b;
      r = $urandom_range(0, 9);
      if (r <= 5)      b = pool[$urandom_range(0, 21)];
      else if (r == 6) b = 8'h0D;
      else if (r == 7) b = 8'($urandom_range(0, 255));
      else             b = pool[$urandom_range(0, 15)];
      step(1'b1, b, $sformatf("rnd%0d", n));
      if ($urandom_range(0, 3) == 0) begin
        int gap;
        gap = $urandom_range(0, 12);
        for (int g = 0; g < gap; g++) step(1'b0, 8'h00, $sformatf("rnd%0d_gap%0d", n, g));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
